crc_stream_engine: RTL

Streaming, multi-beat CRC engine: the parametrised successor to the single-word sequential CRC generator and checker. It accepts a frame as a sequence of DATA_WIDTH-bit beats over a valid/ready handshake and folds BITS_PER_CYCLE bits per clock into the CRC register. It either generates the frame CRC or checks a frame that carries its CRC appended. It sits between the framing logic and the FEC encoder/decoder datapath, replacing separate generator and verifier instances.

---
 rtl/crc_stream_engine.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/crc_stream_engine.sv
// Streaming multi-beat CRC engine: folds BITS_PER_CYCLE bits per clock into the CRC
// register. It either generates the frame CRC or checks a frame that carries its CRC.
module crc_stream_engine #(
    parameter int                   DATA_WIDTH     = 8,
    parameter int                   CRC_WIDTH      = 16,
    parameter logic [CRC_WIDTH:0]   POLY           = 17'h11021,
    parameter logic [CRC_WIDTH-1:0] SEED           = 16'hFFFF,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT        = 16'h0000,
    parameter logic [CRC_WIDTH-1:0] RESIDUE        = 16'h0000,
    parameter int                   BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic                  abort,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CRC_WIDTH-1:0]  crc_out,
    output logic                  crc_ok,
    output logic [15:0]           frame_beats
);

    // state  | meaning
    // IDLE   | s_ready=1, waiting for a beat
    // CALC   | folding the latched beat into the CRC, BITS_PER_CYCLE bits per cycle
    // RESULT | m_valid=1, holding the registered result until m_ready

    localparam int K      = DATA_WIDTH / BITS_PER_CYCLE;
    localparam int STEP_W = $clog2(K + 1);
    localparam logic [STEP_W-1:0] K_INIT = STEP_W'(K);

    if ((BITS_PER_CYCLE < 1) || ((DATA_WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bpc_check
        $error("crc_stream_engine: BITS_PER_CYCLE must evenly divide DATA_WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_RESULT
    } state_t;

    state_t                  state_q, state_d;
    logic [CRC_WIDTH-1:0]    crc_q, crc_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic                    last_q, last_d;
    logic                    mode_q, mode_d;
    logic                    new_frame_q, new_frame_d;
    logic [15:0]             beat_cnt_q, beat_cnt_d;
    logic [CRC_WIDTH-1:0]    crc_out_q, crc_out_d;
    logic                    crc_ok_q, crc_ok_d;
    logic [15:0]             frame_beats_q, frame_beats_d;

    logic [CRC_WIDTH-1:0]    crc_step;
    logic [DATA_WIDTH-1:0]   shift_step;
    logic                    fb;
    logic [15:0]             beat_base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            crc_q         <= SEED;
            shift_q       <= '0;
            step_q        <= '0;
            last_q        <= 1'b0;
            mode_q        <= 1'b0;
            new_frame_q   <= 1'b1;
            beat_cnt_q    <= '0;
            crc_out_q     <= '0;
            crc_ok_q      <= 1'b0;
            frame_beats_q <= '0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            shift_q       <= shift_d;
            step_q        <= step_d;
            last_q        <= last_d;
            mode_q        <= mode_d;
            new_frame_q   <= new_frame_d;
            beat_cnt_q    <= beat_cnt_d;
            crc_out_q     <= crc_out_d;
            crc_ok_q      <= crc_ok_d;
            frame_beats_q <= frame_beats_d;
        end
    end

    // Serial LFSR unrolled BITS_PER_CYCLE times, message bits taken MSB first.
    always_comb begin
        crc_step   = crc_q;
        shift_step = shift_q;
        fb         = 1'b0;
        for (int b = 0; b < BITS_PER_CYCLE; b++) begin
            fb         = shift_step[DATA_WIDTH-1] ^ crc_step[CRC_WIDTH-1];
            crc_step   = (crc_step << 1) ^ ({CRC_WIDTH{fb}} & POLY[CRC_WIDTH-1:0]);
            shift_step = shift_step << 1;
        end
    end

    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        shift_d       = shift_q;
        step_d        = step_q;
        last_d        = last_q;
        mode_d        = mode_q;
        new_frame_d   = new_frame_q;
        beat_cnt_d    = beat_cnt_q;
        crc_out_d     = crc_out_q;
        crc_ok_d      = crc_ok_q;
        frame_beats_d = frame_beats_q;
        beat_base     = new_frame_q ? 16'd0 : beat_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    if (new_frame_q) begin
                        crc_d  = SEED;
                        mode_d = mode;
                    end
                    beat_cnt_d  = (beat_base == 16'hFFFF) ? beat_base : beat_base + 16'd1;
                    shift_d     = s_data;
                    last_d      = s_last;
                    step_d      = K_INIT;
                    new_frame_d = 1'b0;
                    state_d     = ST_CALC;
                end
            end
            ST_CALC: begin
                crc_d   = crc_step;
                shift_d = shift_step;
                step_d  = step_q - STEP_W'(1);
                if (step_q == STEP_W'(1)) begin
                    if (last_q) begin
                        state_d       = ST_RESULT;
                        crc_out_d     = crc_step ^ XOR_OUT;
                        crc_ok_d      = mode_q && (crc_step == RESIDUE);
                        frame_beats_d = beat_cnt_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RESULT: begin
                if (m_ready) begin
                    state_d     = ST_IDLE;
                    new_frame_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including a beat offered this same cycle.
        if (abort) begin
            state_d     = ST_IDLE;
            new_frame_d = 1'b1;
            crc_d       = SEED;
            step_d      = '0;
        end
    end

    assign s_ready     = (state_q == ST_IDLE);
    assign m_valid     = (state_q == ST_RESULT);
    assign crc_out     = crc_out_q;
    assign crc_ok      = crc_ok_q;
    assign frame_beats = frame_beats_q;

endmodule
